// File: rtl/instr_encoder_if.sv
// Instruction encoder bus: field/handshake input side plus the
// instruction-memory write side. The master modport belongs to whoever supplies
// fields and consumes memory writes. The slave modport belongs to the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [63:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs R/LOAD/STORE/BRANCH fields into a 32-bit RV word and
// streams it, with sequential word addresses, into instruction memory through
// a single output register stage.
// Optional feature macro: ENC_RANGE_CHECK_EN. When it is defined, a non-R input
// whose immediate does not fit 12 signed bits is consumed but dropped, and is
// counted. When it is undefined, the immediate is truncated to the field bits.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  instr_encoder_if.slave  enc,
  output logic            wrapped,
  output logic            range_err,
  output logic [7:0]      err_count
);

  localparam logic [1:0] FMT_R      = 2'b00;
  localparam logic [1:0] FMT_LOAD   = 2'b01;
  localparam logic [1:0] FMT_STORE  = 2'b10;
  localparam logic [1:0] FMT_BRANCH = 2'b11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_out_valid;
  logic              r_wrapped;

  logic [31:0]       w_word;
  logic              w_in_ready;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_load;
  logic              w_addr_last;

  // Pack the fields into an instruction word. BRANCH immediates arrive in
  // halfword units, so imm[11] lands in word bit 31 and imm[10] lands in bit 7.
  always_comb begin
    w_word = 32'h0;
    case (enc.fmt)
      FMT_R:
        w_word = {enc.funct7, enc.rs2, enc.rs1, enc.funct3, enc.rd, OP_R};
      FMT_LOAD:
        w_word = {enc.imm[11:0], enc.rs1, enc.funct3, enc.rd, OP_LOAD};
      FMT_STORE:
        w_word = {enc.imm[11:5], enc.rs2, enc.rs1, enc.funct3,
                  enc.imm[4:0], OP_STORE};
      FMT_BRANCH:
        w_word = {enc.imm[11], enc.imm[9:4], enc.rs2, enc.rs1, enc.funct3,
                  enc.imm[3:0], enc.imm[10], OP_BRANCH};
      default:
        w_word = 32'h0;
    endcase
  end

  // Clear blocks acceptance outright, so a clear always beats an input handshake.
  assign w_in_ready  = !clear && (!r_out_valid || enc.out_ready);
  assign w_in_hs     = enc.in_valid && w_in_ready;
  assign w_out_hs    = r_out_valid && enc.out_ready;
  assign w_addr_last = (r_addr == {ADDR_W{1'b1}});

`ifdef ENC_RANGE_CHECK_EN
  logic       w_imm_ok;
  logic       w_rng_bad;
  logic       r_range_err;
  logic [7:0] r_err_count;

  // A 12-bit signed field holds the value only if bits 63..11 are all copies of the sign bit.
  assign w_imm_ok  = (&enc.imm[63:11]) || !(|enc.imm[63:11]);
  assign w_rng_bad = w_in_hs && (enc.fmt != FMT_R) && !w_imm_ok;
  assign w_load    = w_in_hs && !w_rng_bad;

  // Sticky error flag and saturating error counter for dropped inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_range_err <= 1'b0;
      r_err_count <= 8'h00;
    end else if (clear) begin
      r_range_err <= 1'b0;
      r_err_count <= 8'h00;
    end else if (w_rng_bad) begin
      r_range_err <= 1'b1;
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign range_err = r_range_err;
  assign err_count = r_err_count;
`else
  assign w_load    = w_in_hs;
  assign range_err = 1'b0;
  assign err_count = 8'h00;
`endif

  // Output stage. A new word replaces a departing one in the same cycle.
  // The address advances once per completed memory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_wdata     <= 32'h0;
      r_addr      <= '0;
      r_wrapped   <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_wdata     <= 32'h0;
      r_addr      <= '0;
      r_wrapped   <= 1'b0;
    end else begin
      if (w_load) begin
        r_wdata     <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_out_hs) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (w_addr_last) begin
          r_wrapped <= 1'b1;
        end
      end
    end
  end

  assign enc.in_ready  = w_in_ready;
  assign enc.out_valid = r_out_valid;
  assign enc.mem_addr  = r_addr;
  assign enc.mem_wdata = r_wdata;
  assign wrapped       = r_wrapped;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader: packs register fields, funct codes and a 64-bit sign-extended immediate into a 32-bit RV instruction word and streams it, with sequential word addresses, into instruction memory. It is the inverse of the decode-stage immediate generator for the R, LOAD, STORE and BRANCH formats, so any accepted word decodes back to the supplied immediate. It is used by the test/boot path to fill instruction memory and to build round-trip vectors for the decode stage.

## Interface
- ADDR_W, 8, word-address width; memory depth 2^ADDR_W words
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of address, counters, flags and held word
- in_valid  in  1  input word request
- in_ready  out  1  encoder can accept this cycle
- fmt  in  2  00 R, 01 LOAD, 10 STORE, 11 BRANCH
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3;  funct7  in  7 (R only)
- imm  in  64  sign-extended immediate; BRANCH imm is in halfword units (byte offset / 2)
- out_valid  out  1  mem_wdata/mem_addr valid
- out_ready  in  1  memory accepts word
- mem_addr  out  ADDR_W  word address of held word
- mem_wdata  out  32  encoded instruction
- wrapped  out  1  sticky: address passed 2^ADDR_W-1
- range_err  out  1  sticky: immediate out of range seen
- err_count  out  8  saturating count of range errors

## Operation
- Opcodes: R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- R: {funct7, rs2, rs1, funct3, rd, op}; imm ignored, never a range error.
- LOAD: {imm[11:0], rs1, funct3, rd, op}.
- STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- BRANCH: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], op} (halfword units).
- Range check (non-R): in range iff imm[63:11] all equal.
- Single output register stage. in_ready = !clear && (!out_valid || out_ready).
- Input handshake (in_valid && in_ready): encoded word loaded, out_valid=1 next cycle.
- Output handshake (out_valid && out_ready): mem_addr increments next cycle, wraps 2^ADDR_W-1 -> 0 and sets wrapped.
- Both handshakes same cycle: new word loaded, out_valid stays 1, address increments once.
- Held word, address and out_valid stable while out_valid && !out_ready.
- clear: next cycle out_valid=0, mem_addr=0, wrapped=0, range_err=0, err_count=0; held word dropped; beats any handshake that cycle.
- err_count saturates at 255.

## Timing
- Reset (async, immediate): out_valid=0, mem_addr=0, mem_wdata=0, wrapped=0, range_err=0, err_count=0; in_ready=1 once rst deasserts.
- Latency: input accepted at edge N -> out_valid/mem_wdata valid after edge N.
- Throughput: one word per cycle with out_ready held high.
- rst mid-stream: held word lost, no partial write (out_valid drops asynchronously).
- range_err/err_count update at the edge following the offending input handshake.

## Configuration
- ENC_RANGE_CHECK_EN defined: out-of-range non-R input is consumed (in_ready handshake completes) but dropped; out_valid not asserted for it, address unchanged; range_err set, err_count incremented.
- Not defined: no check; immediate silently truncated to the field bits and written normally; range_err and err_count tie to 0.

## Test plan
- LOAD rd=5 rs1=2 funct3=010 imm=8, out_ready=1 -> mem_wdata=0x00812283 at mem_addr 0, one cycle after acceptance.
- STORE rs2=5 rs1=2 funct3=010 imm=-4 -> 0xFE512E23; R funct7=0 rs2=2 rs1=1 funct3=0 rd=3 -> 0x002081B3 at next address.
- LOAD imm=2048: with ENC_RANGE_CHECK_EN -> no write, range_err=1, err_count=1, mem_addr unchanged; without -> word 0x80000003-class with imm field 0x800 written.
- out_ready=0 for 3 cycles, two inputs offered -> in_ready=0 after first, word stable; both written in order at addresses 0,1.
- ADDR_W=2, five back-to-back words -> addresses 0,1,2,3,0; wrapped=1 after fourth write; clear -> mem_addr=0, wrapped=0.
- Round trip: random LOAD/STORE/BRANCH with in-range imm -> decode-stage immediate of mem_wdata equals imm; rst asserted with word held -> out_valid=0 immediately.
